// File: rtl/trace_capture_ctrl_pkg.sv
// rtl/trace_capture_ctrl_pkg.sv - shared types and widths for the trace capture path
// Purpose: capture FSM state encoding and default field widths.
// Ports: none (package).
package trace_capture_ctrl_pkg;

  // Encoding is visible on the state output: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } trace_state_t;

  localparam int TRACE_TIME_W  = 64;
  localparam int TRACE_DATA_W  = 18;
  localparam int TRACE_DECIM_W = 16;
  localparam int TRACE_CNT_W   = 20;

endpackage

// File: rtl/trace_out_slot.sv
// rtl/trace_out_slot.sv - single-entry valid/ready output holding register
// Purpose: holds one (time, value) sample for the sink; drops and flags a kept
//          sample that arrives while the slot is full and not being drained.
// Ports: clk, rst_n         clock, async active-low reset
//        i_flush            empty the slot (abort)
//        i_clr_ovf          clear the sticky overflow flag (accepted arm)
//        i_keep/i_time/i_data  kept sample offered to the slot
//        i_ready            sink accepts the pending entry this cycle
//        o_valid/o_time/o_data  pending entry
//        o_overflow         sticky drop indicator
module trace_out_slot #(
  parameter int TIME_W = 64,
  parameter int DATA_W = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_clr_ovf,
  input  logic              i_keep,
  input  logic [TIME_W-1:0] i_time,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [TIME_W-1:0] o_time,
  output logic [DATA_W-1:0] o_data,
  output logic              o_overflow
);

  logic              r_valid;
  logic [TIME_W-1:0] r_time;
  logic [DATA_W-1:0] r_data;
  logic              r_ovf;
  logic              w_load;
  logic              w_drop;

  // The slot can take a new sample when empty or when its current entry
  // leaves in this same cycle.
  assign w_load = i_keep & ~i_flush & (~r_valid | i_ready);
  assign w_drop = i_keep & ~i_flush & r_valid & ~i_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_time  <= '0;
      r_data  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (i_flush) begin
        r_valid <= 1'b0;
      end else if (w_load) begin
        r_valid <= 1'b1;
        r_time  <= i_time;
        r_data  <= i_data;
      end else if (i_ready) begin
        r_valid <= 1'b0;
      end

      if (i_clr_ovf) begin
        r_ovf <= 1'b0;
      end else if (w_drop) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign o_valid    = r_valid;
  assign o_time     = r_time;
  assign o_data     = r_data;
  assign o_overflow = r_ovf;

endmodule

// File: rtl/trace_capture_ctrl.sv
// rtl/trace_capture_ctrl.sv - armed, triggered, decimated trace capture sequencer
// Purpose: arms on command, waits for in_time >= trig_time, then forwards a
//          decimated window of num_samples kept samples to one sink.
// Ports: clk, rst_n                 clock, async active-low reset
//        arm, abort                 control pulses (abort wins)
//        trig_time, decim, num_samples  capture settings, latched on arm
//        in_valid, in_time, in_data probe stream
//        out_valid, out_ready, out_time, out_data  sink handshake
//        busy, done, overflow, state  status
module trace_capture_ctrl
  import trace_capture_ctrl_pkg::*;
#(
  parameter int TIME_W  = TRACE_TIME_W,
  parameter int DATA_W  = TRACE_DATA_W,
  parameter int DECIM_W = TRACE_DECIM_W,
  parameter int CNT_W   = TRACE_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arm,
  input  logic               abort,
  input  logic [TIME_W-1:0]  trig_time,
  input  logic [DECIM_W-1:0] decim,
  input  logic [CNT_W-1:0]   num_samples,
  input  logic               in_valid,
  input  logic [TIME_W-1:0]  in_time,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [TIME_W-1:0]  out_time,
  output logic [DATA_W-1:0]  out_data,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic [1:0]         state
);

  trace_state_t       r_state;
  trace_state_t       w_state_nxt;
  logic [TIME_W-1:0]  r_trig_time;
  logic [DECIM_W-1:0] r_decim;
  logic [CNT_W-1:0]   r_num_samples;
  logic [CNT_W-1:0]   r_sample_cnt;
  logic [CNT_W-1:0]   w_sample_cnt_nxt;
  logic [DECIM_W-1:0] r_dec_cnt;
  logic [DECIM_W-1:0] w_dec_cnt_nxt;
  logic [CNT_W-1:0]   w_sample_inc;
  logic               w_in_ok;
  logic               w_hit;
  logic               w_keep;
  logic               w_arm_ok;

  // A timestamp with unknown bits must not trigger or advance decimation.
  assign w_in_ok      = in_valid & ~$isunknown(in_time);
  assign w_hit        = w_in_ok & (in_time >= r_trig_time);
  assign w_sample_inc = r_sample_cnt + CNT_W'(1);

  always_comb begin
    w_state_nxt      = r_state;
    w_sample_cnt_nxt = r_sample_cnt;
    w_dec_cnt_nxt    = r_dec_cnt;
    w_keep           = 1'b0;
    w_arm_ok         = 1'b0;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (arm) begin
            w_arm_ok         = 1'b1;
            w_sample_cnt_nxt = '0;
            w_dec_cnt_nxt    = '0;
            w_state_nxt      = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (w_hit) begin
            if (r_num_samples == '0) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_keep           = 1'b1;
              w_sample_cnt_nxt = CNT_W'(1);
              w_dec_cnt_nxt    = '0;
              w_state_nxt      = (r_num_samples == CNT_W'(1)) ? ST_DONE : ST_CAPTURE;
            end
          end
        end
        ST_CAPTURE: begin
          if (w_in_ok) begin
            if (r_dec_cnt == r_decim) begin
              // Kept even if the slot drops it, so the window length in
              // simulated time does not depend on sink backpressure.
              w_keep           = 1'b1;
              w_dec_cnt_nxt    = '0;
              w_sample_cnt_nxt = w_sample_inc;
              if (w_sample_inc >= r_num_samples) begin
                w_state_nxt = ST_DONE;
              end
            end else begin
              w_dec_cnt_nxt = r_dec_cnt + DECIM_W'(1);
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_trig_time   <= '0;
      r_decim       <= '0;
      r_num_samples <= '0;
      r_sample_cnt  <= '0;
      r_dec_cnt     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_sample_cnt <= w_sample_cnt_nxt;
      r_dec_cnt    <= w_dec_cnt_nxt;
      if (w_arm_ok) begin
        r_trig_time   <= trig_time;
        r_decim       <= decim;
        r_num_samples <= num_samples;
      end
    end
  end

  trace_out_slot #(
    .TIME_W (TIME_W),
    .DATA_W (DATA_W)
  ) u_slot (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_flush    (abort),
    .i_clr_ovf  (w_arm_ok),
    .i_keep     (w_keep),
    .i_time     (in_time),
    .i_data     (in_data),
    .i_ready    (out_ready),
    .o_valid    (out_valid),
    .o_time     (out_time),
    .o_data     (out_data),
    .o_overflow (overflow)
  );

  assign state = r_state;
  assign busy  = (r_state == ST_ARMED) || (r_state == ST_CAPTURE);
  assign done  = (r_state == ST_DONE);

endmodule

// File: tb/tb_trace_capture_ctrl.sv
// tb/tb_trace_capture_ctrl.sv - self-checking bench for trace_capture_ctrl
module tb_trace_capture_ctrl;

  logic        clk;
  logic        rst_n;
  logic        arm;
  logic        abort;
  logic [63:0] trig_time;
  logic [15:0] decim;
  logic [19:0] num_samples;
  logic        in_valid;
  logic [63:0] in_time;
  logic [17:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_time;
  logic [17:0] out_data;
  logic        busy;
  logic        done;
  logic        overflow;
  logic [1:0]  state;

  trace_capture_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .arm         (arm),
    .abort       (abort),
    .trig_time   (trig_time),
    .decim       (decim),
    .num_samples (num_samples),
    .in_valid    (in_valid),
    .in_time     (in_time),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_time    (out_time),
    .out_data    (out_data),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .state       (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: capture phase, window settings, and sample bookkeeping
  // expressed as "samples seen since trigger" and "samples kept".
  int          m_state;
  logic [63:0] m_trig;
  int          m_decim;
  int          m_num;
  int          m_kept;
  longint      m_seen;
  bit          m_v;
  logic [63:0] m_ot;
  logic [17:0] m_od;
  bit          m_ovf;

  logic [63:0] acc_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_trig = '0; m_decim = 0; m_num = 0;
    m_kept = 0; m_seen = 0; m_v = 0; m_ot = '0; m_od = '0; m_ovf = 0;
  endtask

  task automatic model_step();
    bit keep;
    keep = 0;
    if (abort) begin
      m_state = 0;
    end else if (arm && (m_state == 0 || m_state == 3)) begin
      m_state = 1; m_trig = trig_time; m_decim = int'(decim); m_num = int'(num_samples);
      m_kept = 0; m_seen = 0; m_ovf = 0;
    end else if (m_state == 1) begin
      if (in_valid && in_time >= m_trig) begin
        if (m_num == 0) m_state = 3;
        else begin
          keep = 1; m_kept = 1; m_seen = 1;
          m_state = (m_num == 1) ? 3 : 2;
        end
      end
    end else if (m_state == 2 && in_valid) begin
      if (m_seen % longint'(m_decim + 1) == 0) begin
        keep = 1; m_kept++;
        if (m_kept == m_num) m_state = 3;
      end
      m_seen++;
    end
    if (abort) m_v = 0;
    else if (keep) begin
      if (!m_v || out_ready) begin m_v = 1; m_ot = in_time; m_od = in_data; end
      else m_ovf = 1;
    end else if (out_ready) m_v = 0;
  endtask

  task automatic compare();
    chk("state", 64'(state), 64'(m_state));
    chk("out_valid", 64'(out_valid), 64'(m_v));
    if (m_v) begin
      chk("out_time", out_time, m_ot);
      chk("out_data", 64'(out_data), 64'(m_od));
    end
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("busy", 64'(busy), 64'(m_state == 1 || m_state == 2));
    chk("done", 64'(done), 64'(m_state == 3));
  endtask

  task automatic cyc(input bit a, input bit ab, input bit iv, input logic [63:0] t,
                     input logic [17:0] d, input bit rdy);
    arm = a; abort = ab; in_valid = iv; in_time = t; in_data = d; out_ready = rdy;
    #1;
    if (out_valid && out_ready) acc_q.push_back(out_time);
    @(posedge clk);
    if (rst_n) model_step(); else model_reset();
    @(negedge clk);
    compare();
  endtask

  task automatic chk_log(input string name, input logic [63:0] exp[$]);
    chk({name, "_count"}, 64'(acc_q.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < acc_q.size(); i++) chk(name, acc_q[i], exp[i]);
  endtask

  logic [17:0] rd;

  initial begin
    logic [63:0] cur;
    int   tt[8];
    bit   vv[8];
    tt = '{30, 31, 0, 32, 33, 34, 35, 36};
    vv = '{1, 1, 0, 1, 1, 1, 1, 1};
    rst_n = 0; arm = 0; abort = 0; trig_time = '0; decim = '0; num_samples = '0;
    in_valid = 0; in_time = '0; in_data = '0; out_ready = 0;
    model_reset();
    #1;
    chk("rst_state", 64'(state), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_time", out_time, 0);
    chk("rst_out_data", 64'(out_data), 0);
    chk("rst_overflow", 64'(overflow), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    rst_n = 1;

    // Basic capture
    trig_time = 100; decim = 0; num_samples = 4;
    cyc(1, 0, 0, 0, 0, 1);
    acc_q.delete();
    for (int t = 98; t <= 110; t++) cyc(0, 0, 1, 64'(t), 18'($urandom), 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk_log("basic", '{64'd100, 64'd101, 64'd102, 64'd103});
    chk("basic_done", 64'(done), 1);

    // Decimation, continuous then with an in_valid gap
    trig_time = 0; decim = 2; num_samples = 3;
    cyc(1, 0, 0, 0, 0, 1);
    acc_q.delete();
    for (int t = 10; t <= 25; t++) cyc(0, 0, 1, 64'(t), 18'($urandom), 1);
    chk_log("decim", '{64'd10, 64'd13, 64'd16});
    cyc(1, 0, 0, 0, 0, 1);
    acc_q.delete();
    for (int k = 0; k < 8; k++) cyc(0, 0, vv[k], 64'(tt[k]), 18'($urandom), 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk_log("decim_gap", '{64'd30, 64'd33, 64'd36});

    // Backpressure
    trig_time = 0; decim = 0; num_samples = 5;
    cyc(1, 0, 0, 0, 0, 1);
    acc_q.delete();
    for (int k = 0; k < 8; k++) cyc(0, 0, 1, 64'(200 + k), 18'($urandom), !(k >= 1 && k <= 3));
    chk_log("bp", '{64'd200, 64'd204});
    chk("bp_overflow", 64'(overflow), 1);
    chk("bp_state", 64'(state), 3);
    cyc(1, 0, 0, 0, 0, 1);
    chk("bp_rearm_overflow", 64'(overflow), 0);

    // num_samples = 0
    cyc(0, 1, 0, 0, 0, 1);
    trig_time = 0; num_samples = 0;
    cyc(1, 0, 0, 0, 0, 1);
    acc_q.delete();
    cyc(0, 0, 1, 300, 5, 1);
    chk("n0_state", 64'(state), 3);
    for (int k = 0; k < 3; k++) cyc(0, 0, 1, 64'(301 + k), 5, 1);
    chk("n0_outputs", 64'(acc_q.size()), 0);
    chk("n0_out_valid", 64'(out_valid), 0);

    // arm + abort from DONE
    cyc(1, 1, 0, 0, 0, 1);
    chk("armabort_state", 64'(state), 0);

    // arm while ARMED keeps the first trig_time; abort during CAPTURE
    trig_time = 500; decim = 0; num_samples = 10;
    cyc(1, 0, 0, 0, 0, 1);
    trig_time = 50;
    cyc(1, 0, 0, 0, 0, 1);
    cyc(0, 0, 1, 100, 1, 0);
    chk("rearm_state", 64'(state), 1);
    cyc(0, 0, 1, 600, 2, 0);
    chk("trig_state", 64'(state), 2);
    chk("trig_out_valid", 64'(out_valid), 1);
    cyc(0, 1, 1, 601, 3, 0);
    chk("abort_state", 64'(state), 0);
    chk("abort_out_valid", 64'(out_valid), 0);

    // Asynchronous reset mid-capture
    trig_time = 0; decim = 0; num_samples = 50;
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 1, 64'(700 + k), 7, 0);
    rst_n = 0;
    #1;
    chk("arst_state", 64'(state), 0);
    chk("arst_out_valid", 64'(out_valid), 0);
    chk("arst_overflow", 64'(overflow), 0);
    model_reset();
    cyc(0, 0, 0, 0, 0, 0);
    rst_n = 1;

    // Randomized episodes
    cur = 1000;
    for (int ep = 0; ep < 40; ep++) begin
      if (ep == 20) cur = 64'h8000_0000_0000_0000;
      trig_time   = cur + 64'($urandom_range(0, 20));
      decim       = 16'($urandom_range(0, 3));
      num_samples = 20'($urandom_range(0, 6));
      for (int c = 0; c < 80; c++) begin
        if ($urandom_range(0, 7) == 0) begin
          trig_time   = cur + 64'($urandom_range(0, 30));
          decim       = 16'($urandom_range(0, 3));
          num_samples = 20'($urandom_range(0, 6));
        end
        cur = cur + 64'($urandom_range(1, 3));
        rd  = 18'($urandom);
        cyc(c == 0 || $urandom_range(0, 29) == 0, $urandom_range(0, 59) == 0,
            $urandom_range(0, 9) < 7, cur, rd, $urandom_range(0, 9) < 6);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trace_capture_ctrl.md
Name: trace_capture_ctrl

Overview:
- Sequences the emulator's trace-logging path: arms on command, waits for a simulated-time trigger, then forwards a decimated, length-limited window of (time, value) samples to a single logging sink.
- Sits between the per-cycle probe stream (TIME_FORMAT timestamp plus FILTER_OUT_FORMAT value) and the host-side trace writer.
- Makes capture bounded and synthesizable instead of logging every cycle unconditionally.

Parameters:
- TIME_W, 64, width of the timestamp; must equal the bit width of TIME_FORMAT.
- DATA_W, 18, width of the sampled value; must equal the bit width of FILTER_OUT_FORMAT.
- DECIM_W, 16, width of the decimation ratio input.
- CNT_W, 20, width of the sample-count input and counter.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- arm  in  1  single-cycle pulse; starts a capture.
- abort  in  1  single-cycle pulse; cancels any capture.
- trig_time  in  TIME_W  capture begins at the first valid sample with in_time >= trig_time (unsigned).
- decim  in  DECIM_W  keep one of every decim+1 samples.
- num_samples  in  CNT_W  number of kept samples per capture.
- in_valid  in  1  probe sample present this cycle.
- in_time  in  TIME_W  sample timestamp.
- in_data  in  DATA_W  sample value.
- out_valid  out  1  output sample pending.
- out_ready  in  1  sink accepts the output this cycle.
- out_time  out  TIME_W  timestamp of the pending output sample.
- out_data  out  DATA_W  value of the pending output sample.
- busy  out  1  high in ARMED or CAPTURE.
- done  out  1  high in DONE.
- overflow  out  1  sticky; a kept sample was dropped.
- state  out  2  encoded state: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; out_valid=0; out_time=0; out_data=0; overflow=0; all counters 0; busy=0; done=0.
- arm in IDLE or DONE:
  - latch trig_time, decim and num_samples into shadow registers;
  - clear overflow and both counters;
  - next state = ARMED.
- arm in ARMED or CAPTURE: ignored.
- abort in any state: next state = IDLE and out_valid cleared on the next edge. abort wins over a simultaneous arm.
- ARMED:
  - A sample with in_valid=1 and in_time >= latched trig_time is the trigger sample. It is kept, sample_cnt becomes 1, dec_cnt becomes 0, and the state moves to CAPTURE.
  - If the latched num_samples==0, no sample is kept and the state moves straight to DONE.
- CAPTURE:
  - On each in_valid=1 cycle: if dec_cnt==decim, the sample is kept and dec_cnt goes to 0; otherwise dec_cnt increments.
  - decim=0 keeps every valid sample.
  - Cycles with in_valid=0 do not advance dec_cnt.
  - On every kept sample, sample_cnt increments. A dropped sample still counts, so the window spans a fixed amount of simulated time.
  - When sample_cnt reaches num_samples, the state moves to DONE.
  - A num_samples of 1 goes from ARMED to DONE on the trigger sample.
- Samples whose in_time contains X/Z are treated as in_valid=0 in simulation.
- Output register (single entry, one-cycle latency from a kept input to out_valid):
  - A kept sample loads out_time/out_data and sets out_valid if the slot is empty (out_valid=0) or is being consumed in the same cycle (out_valid & out_ready).
  - If the slot is full and not consumed, the kept sample is dropped and overflow is set. overflow stays set until the next arm.
  - out_valid clears when out_ready=1 and no new sample loads.
  - out_time and out_data hold their values while out_valid=1 and out_ready=0.
- DONE:
  - The last kept sample remains in the output register until it is drained.
  - done=1 from the cycle after the transition.
  - The state holds until arm or abort.
- Counters saturate, never wrap: sample_cnt never exceeds num_samples; dec_cnt never exceeds decim.
- Timestamp comparison is unsigned, full TIME_W. A trig_time of 0 triggers on the first valid sample.

Decomposition:
- Add to signal_package:
  - trace_state_t, an enum for IDLE/ARMED/CAPTURE/DONE;
  - localparams TRACE_DECIM_W and TRACE_CNT_W.
- TIME_FORMAT stays in time_package; FILTER_OUT_FORMAT stays in signal_package. The port types are bound to these.
- One natural sub-module: trace_out_slot, the single-entry valid/ready holding register with drop/overflow detection. The FSM and counters stay in the top module.

Test Plan:
- Reset mid-CAPTURE: with out_valid=1, assert rst_n=0 -> state=0, out_valid=0 and overflow=0 immediately, with no clock edge required.
- Basic capture: trig_time=100, decim=0, num_samples=4, input times 98..110 every cycle, out_ready=1 -> outputs at times 100, 101, 102, 103; done=1; no further outputs.
- Decimation: trig_time=0, decim=2, num_samples=3, valid every cycle from time 10 -> outputs at times 10, 13, 16; dec_cnt pauses on in_valid=0 gaps.
- Backpressure: decim=0, num_samples=5, out_ready=0 for 3 cycles -> first sample held stable, samples 2..4 dropped, overflow=1, state reaches DONE after 5 kept samples; a following arm clears overflow.
- Simultaneous events: arm+abort in the same cycle from DONE -> IDLE. abort during CAPTURE with out_valid=1 -> IDLE and out_valid=0 next cycle. arm during ARMED -> no change to the latched trig_time.
- Edge case: arm with num_samples=0 -> ARMED, then DONE on the first qualifying sample, with out_valid never asserted.
